// File: rtl/regfile_writeback_arbiter.sv
// Two-source writeback arbiter for the register file's single write port (A = execute, B = load).
// Define WB_SCOREBOARD_EN to build the outstanding-load scoreboard; otherwise busy reads as zero.
module regfile_writeback_arbiter #(
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [4:0]  a_rd,
    input  logic [31:0] a_data,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [4:0]  b_rd,
    input  logic [31:0] b_data,
    output logic [4:0]  write_register,
    output logic [31:0] write_value,
    input  logic        alloc_valid,
    input  logic [4:0]  alloc_rd,
    output logic [15:0] busy
);

    localparam logic [3:0] STARVE_LIM4 = 4'(STARVE_LIMIT);

    logic        a_full_q, a_full_d;
    logic [3:0]  a_rd_q, a_rd_d;
    logic [31:0] a_data_q, a_data_d;
    logic        b_full_q, b_full_d;
    logic [3:0]  b_rd_q, b_rd_d;
    logic [31:0] b_data_q, b_data_d;
    logic [3:0]  starve_q, starve_d;
    logic [4:0]  wr_reg_q, wr_reg_d;
    logic [31:0] wr_val_q, wr_val_d;

    logic grant_a, grant_b;
    logic a_keep, b_keep;

    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (a_full_q && b_full_q) begin
            grant_a = (starve_q >= STARVE_LIM4);
            grant_b = !grant_a;
        end else begin
            grant_a = a_full_q;
            grant_b = b_full_q;
        end

        // ready is gated by reset and slot state only, never by valid
        a_ready = rst_n && (!a_full_q || grant_a);
        b_ready = rst_n && (!b_full_q || grant_b);

        // rd 0 and rd 16..31 complete the handshake but are dropped
        a_keep = a_valid && a_ready && (a_rd[3:0] != 4'd0) && !a_rd[4];
        b_keep = b_valid && b_ready && (b_rd[3:0] != 4'd0) && !b_rd[4];

        a_full_d = a_keep ? 1'b1 : (grant_a ? 1'b0 : a_full_q);
        a_rd_d   = a_keep ? a_rd[3:0] : a_rd_q;
        a_data_d = a_keep ? a_data : a_data_q;
        b_full_d = b_keep ? 1'b1 : (grant_b ? 1'b0 : b_full_q);
        b_rd_d   = b_keep ? b_rd[3:0] : b_rd_q;
        b_data_d = b_keep ? b_data : b_data_q;

        if (!a_full_q || grant_a) begin
            starve_d = 4'd0;
        end else if (starve_q == 4'hF) begin
            starve_d = 4'hF;
        end else begin
            starve_d = starve_q + 4'd1;
        end

        wr_reg_d = 5'd0;
        wr_val_d = 32'd0;
        if (grant_b) begin
            wr_reg_d = {1'b0, b_rd_q};
            wr_val_d = b_data_q;
        end else if (grant_a) begin
            wr_reg_d = {1'b0, a_rd_q};
            wr_val_d = a_data_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_full_q <= 1'b0;
            a_rd_q   <= 4'd0;
            a_data_q <= 32'd0;
            b_full_q <= 1'b0;
            b_rd_q   <= 4'd0;
            b_data_q <= 32'd0;
            starve_q <= 4'd0;
            wr_reg_q <= 5'd0;
            wr_val_q <= 32'd0;
        end else begin
            a_full_q <= a_full_d;
            a_rd_q   <= a_rd_d;
            a_data_q <= a_data_d;
            b_full_q <= b_full_d;
            b_rd_q   <= b_rd_d;
            b_data_q <= b_data_d;
            starve_q <= starve_d;
            wr_reg_q <= wr_reg_d;
            wr_val_q <= wr_val_d;
        end
    end

    assign write_register = wr_reg_q;
    assign write_value    = wr_val_q;

`ifdef WB_SCOREBOARD_EN
    logic [15:0] busy_q, busy_d;

    // clear on the commit edge; a same-edge alloc to that register wins
    always_comb begin
        busy_d = busy_q;
        if (wr_reg_q != 5'd0) begin
            busy_d[wr_reg_q[3:0]] = 1'b0;
        end
        if (alloc_valid && (alloc_rd[3:0] != 4'd0) && !alloc_rd[4]) begin
            busy_d[alloc_rd[3:0]] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= 16'h0000;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;
`else
    logic unused_alloc;
    assign unused_alloc = ^{alloc_valid, alloc_rd};
    assign busy = 16'h0000;
`endif

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Scoreboard bench for regfile_writeback_arbiter: expected writes are queued at issue, a monitor pops them.
// Busy checks follow WB_SCOREBOARD_EN the same way the design does.
module tb_regfile_writeback_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_valid, b_valid;
    logic        a_ready, b_ready;
    logic [4:0]  a_rd, b_rd;
    logic [31:0] a_data, b_data;
    logic [4:0]  write_register;
    logic [31:0] write_value;
    logic        alloc_valid;
    logic [4:0]  alloc_rd;
    logic [15:0] busy;

    int checks = 0;
    int errors = 0;
    logic [36:0] exp_q[$];

    regfile_writeback_arbiter #(.STARVE_LIMIT(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
        .write_register(write_register), .write_value(write_value),
        .alloc_valid(alloc_valid), .alloc_rd(alloc_rd), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [4:0] rd, input logic [31:0] data);
        exp_q.push_back({rd, data});
    endtask

    // every nonzero write must match the next queued expectation, in order
    always @(negedge clk) begin
        logic [36:0] e;
        if (write_register != 5'd0) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got rd=%0d data=%0h expected none",
                         write_register, write_value);
            end else begin
                e = exp_q.pop_front();
                if ({write_register, write_value} !== e) begin
                    errors++;
                    $display("FAIL write_port: got rd=%0d data=%0h expected rd=%0d data=%0h",
                             write_register, write_value, e[36:32], e[31:0]);
                end
            end
        end
    end

    task automatic check_busy(input string name, input logic [15:0] exp);
`ifdef WB_SCOREBOARD_EN
        check(name, 32'(busy), 32'(exp));
`else
        check(name, 32'(busy), 32'h0);
`endif
    endtask

    initial begin
        rst_n = 1'b0;
        a_valid = 0; a_rd = 0; a_data = 0;
        b_valid = 0; b_rd = 0; b_data = 0;
        alloc_valid = 0; alloc_rd = 0;

        // reset state
        step(); step();
        check("rst_a_ready", 32'(a_ready), 0);
        check("rst_b_ready", 32'(b_ready), 0);
        check("rst_wreg", 32'(write_register), 0);
        check("rst_wval", write_value, 0);
        check_busy("rst_busy", 16'h0);
        rst_n = 1'b1;
        #1;
        check("rel_a_ready", 32'(a_ready), 1);
        check("rel_b_ready", 32'(b_ready), 1);

        // A only
        step();
        a_valid = 1; a_rd = 5; a_data = 32'hDEADBEEF;
        push(5, 32'hDEADBEEF);
        step();
        a_valid = 0;
        check("aonly_ready_granted", 32'(a_ready), 1);
        check("aonly_not_yet", 32'(write_register), 0);
        step();
        check("aonly_wreg", 32'(write_register), 5);
        step();
        check("aonly_wreg_after", 32'(write_register), 0);
        check("aonly_wval_after", write_value, 0);

        // simultaneous: B first, A next
        a_valid = 1; a_rd = 3; a_data = 32'h11;
        b_valid = 1; b_rd = 4; b_data = 32'h22;
        push(4, 32'h22); push(3, 32'h11);
        step();
        a_valid = 0; b_valid = 0;
        check("sim_a_ready_lose", 32'(a_ready), 0);
        check("sim_b_ready_win", 32'(b_ready), 1);
        step();
        check("sim_first_b", 32'(write_register), 4);
        check("sim_a_ready_now", 32'(a_ready), 1);
        step();
        check("sim_second_a", 32'(write_register), 3);
        step();

        // starvation with STARVE_LIMIT=3: writes 8,9,10,7,11
        a_valid = 1; a_rd = 7; a_data = 32'hA7;
        b_valid = 1; b_rd = 8; b_data = 32'hB8;
        push(8, 32'hB8); push(9, 32'hB9); push(10, 32'hBA); push(7, 32'hA7); push(11, 32'hBB);
        step();
        a_valid = 0;
        b_rd = 9; b_data = 32'hB9;
        step();
        check("stv_wr8", 32'(write_register), 8);
        b_rd = 10; b_data = 32'hBA;
        step();
        b_rd = 11; b_data = 32'hBB;
        step();
        b_valid = 0;
        check("stv_a_granted_ready", 32'(a_ready), 1);
        check("stv_b_lose_ready", 32'(b_ready), 0);
        step();
        check("stv_wr7", 32'(write_register), 7);
        step();
        check("stv_wr11", 32'(write_register), 11);
        step();

        // starve count cleared: a new contest goes to B first again
        a_valid = 1; a_rd = 2; a_data = 32'hA2;
        b_valid = 1; b_rd = 1; b_data = 32'hB1;
        push(1, 32'hB1); push(2, 32'hA2);
        step();
        a_valid = 0; b_valid = 0;
        step(); step(); step();

        // discard
        a_valid = 1; a_rd = 0;     a_data = 32'h55;
        b_valid = 1; b_rd = 5'd20; b_data = 32'h66;
        #1;
        check("disc_a_ready", 32'(a_ready), 1);
        check("disc_b_ready", 32'(b_ready), 1);
        step();
        a_valid = 0; b_valid = 0;
        check("disc_a_ready_after", 32'(a_ready), 1);
        check("disc_b_ready_after", 32'(b_ready), 1);
        step();
        check("disc_no_write", 32'(write_register), 0);
        step();

        // scoreboard: set, commit clear
        alloc_valid = 1; alloc_rd = 6;
        step();
        alloc_valid = 0;
        check_busy("sb_set6", 16'h0040);
        alloc_valid = 1; alloc_rd = 0;
        step();
        alloc_valid = 1; alloc_rd = 5'd22;
        step();
        alloc_valid = 0;
        check_busy("sb_ignore_0_22", 16'h0040);
        b_valid = 1; b_rd = 6; b_data = 32'h600;
        push(6, 32'h600);
        step();
        b_valid = 0;
        step();
        check("sb_wr6", 32'(write_register), 6);
        check_busy("sb_still_busy", 16'h0040);
        step();
        check_busy("sb_cleared", 16'h0000);

        // scoreboard: alloc on the clearing edge wins
        alloc_valid = 1; alloc_rd = 6;
        step();
        alloc_valid = 0;
        b_valid = 1; b_rd = 6; b_data = 32'h601;
        push(6, 32'h601);
        step();
        b_valid = 0;
        step();
        alloc_valid = 1; alloc_rd = 6;
        step();
        alloc_valid = 0;
        check_busy("sb_set_wins", 16'h0040);
        step();
        check_busy("sb_set_holds", 16'h0040);

        // reset mid-operation: held entries dropped
        a_valid = 1; a_rd = 9;  a_data = 32'h99;
        b_valid = 1; b_rd = 10; b_data = 32'hAA;
        alloc_valid = 1; alloc_rd = 12;
        step();
        a_valid = 0; b_valid = 0; alloc_valid = 0;
        rst_n = 1'b0;
        step();
        check("mid_rst_wreg", 32'(write_register), 0);
        check("mid_rst_wval", write_value, 0);
        check("mid_rst_a_ready", 32'(a_ready), 0);
        check_busy("mid_rst_busy", 16'h0000);
        rst_n = 1'b1;
        step();
        check("mid_rel_a_ready", 32'(a_ready), 1);
        check("mid_rel_b_ready", 32'(b_ready), 1);
        step(); step(); step();
        check("mid_no_write", 32'(write_register), 0);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_writes: got %0d outstanding expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
